// File: rtl/keyed_rr_arbiter.sv
// Round-robin arbiter sharing one master port among NR_REQ requesters.
// The grant is held as a binary key that steers the payload mux and routes the response.
module keyed_rr_arbiter #(
  parameter int NR_REQ   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NR_REQ-1:0]          i_req_valid,
  input  logic [NR_REQ*DATA_LEN-1:0] i_req_data,
  output logic [NR_REQ-1:0]          o_req_ready,
  output logic                       o_mst_valid,
  output logic [DATA_LEN-1:0]        o_mst_data,
  input  logic                       i_mst_ready,
  input  logic                       i_rsp_valid,
  input  logic [DATA_LEN-1:0]        i_rsp_data,
  output logic [NR_REQ-1:0]          o_rsp_valid,
  output logic [DATA_LEN-1:0]        o_rsp_data,
  output logic [KEY_LEN-1:0]         o_key,
  output logic                       o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state;
  logic [KEY_LEN-1:0] key;
  logic [KEY_LEN-1:0] rr_ptr;
  logic [KEY_LEN-1:0] next_ptr;
  logic [KEY_LEN-1:0] pick;
  logic               pick_found;
  logic               mst_valid;
  logic               busy;

  // Scan rr_ptr, rr_ptr+1, ... wrapping at NR_REQ; first valid requester wins.
  always_comb begin
    int unsigned        idx;
    logic [KEY_LEN-1:0] cand;
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    cand       = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NR_REQ) idx = idx - NR_REQ;
      cand = KEY_LEN'(idx);
      if (!pick_found && i_req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_ptr = key + KEY_LEN'(1);
    if (32'(key) >= NR_REQ - 1) next_ptr = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      key       <= '0;
      rr_ptr    <= '0;
      mst_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            key       <= pick;
            state     <= ISSUE;
            mst_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          if (i_mst_ready) begin
            state     <= WAIT;
            mst_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (i_rsp_valid) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mst_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Key-indexed payload mux plus one-hot ready/response steering.
  always_comb begin
    o_mst_data  = '0;
    o_req_ready = '0;
    o_rsp_valid = '0;
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      if (key == KEY_LEN'(k)) begin
        o_mst_data     = i_req_data[k*DATA_LEN +: DATA_LEN];
        o_req_ready[k] = (state == ISSUE) && i_mst_ready;
        o_rsp_valid[k] = (state == WAIT) && i_rsp_valid;
      end
    end
  end

  assign o_mst_valid = mst_valid;
  assign o_busy      = busy;
  assign o_key       = key;
  assign o_rsp_data  = i_rsp_data;

endmodule
